// File: rtl/crypto_core_scheduler_if.sv
// Bundle of request, core and response signals for the shared cipher core scheduler.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface crypto_core_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 128
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*DATA_W-1:0] req_key;
  logic                      core_start;
  logic [DATA_W-1:0]         core_data;
  logic [DATA_W-1:0]         core_key;
  logic                      core_done;
  logic [DATA_W-1:0]         core_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_data, req_key, core_done, core_result, rsp_ready,
    output req_ready, core_start, core_data, core_key, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_data, req_key, core_done, core_result, rsp_ready,
    input  req_ready, core_start, core_data, core_key, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/crypto_core_scheduler.sv
// Round-robin scheduler sharing one keyed cipher core among NUM_REQ requesters,
// with zero-key rejection, done timeout and zeroization of captured material.
module crypto_core_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 128
)(
  input logic                   clk,
  input logic                   rst,
  crypto_core_scheduler_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              gnt_vld;
  logic [ID_W-1:0]   cap_id;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] cap_key;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic [TMR_W-1:0]  timer;
  logic              key_zero;
  logic              timeout_hit;
  logic [DATA_W-1:0] slot_data [NUM_REQ];
  logic [DATA_W-1:0] slot_key  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot_data[i] = bus.req_data[i*DATA_W +: DATA_W];
    assign slot_key[i]  = bus.req_key[i*DATA_W +: DATA_W];
  end

  // Scan downward so the nearest valid requester after rr_ptr is the last one written.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign key_zero    = (slot_key[gnt_idx] == '0);
  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (gnt_vld) state_nxt = key_zero ? RESP : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.core_done || timeout_hit) state_nxt = RESP;
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign bus.core_start = (state == ISSUE);
  assign bus.core_data  = (state == ISSUE || state == WAIT) ? cap_data : '0;
  assign bus.core_key   = (state == ISSUE || state == WAIT) ? cap_key  : '0;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = (state == RESP) ? cap_id : '0;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      cap_id     <= '0;
      cap_data   <= '0;
      cap_key    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      timer      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (gnt_vld) begin
          cap_id   <= gnt_idx;
          cap_data <= slot_data[gnt_idx];
          cap_key  <= slot_key[gnt_idx];
          rr_ptr   <= gnt_idx;
          if (key_zero) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (bus.core_done) begin
            rsp_data_q <= bus.core_result;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          cap_id     <= '0;
          cap_data   <= '0;
          cap_key    <= '0;
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_crypto_core_scheduler.sv
// Randomized bench for crypto_core_scheduler against a transaction-level reference model.
module tb_crypto_core_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int DATA_W  = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crypto_core_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus();

  crypto_core_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ref_ptr;
  logic [DATA_W-1:0] d [NUM_REQ];
  logic [DATA_W-1:0] k [NUM_REQ];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in cipher: any fixed function of data and key will do.
  function automatic logic [DATA_W-1:0] core_fn(input logic [DATA_W-1:0] dd, input logic [DATA_W-1:0] kk);
    return dd ^ {kk[63:0], kk[127:64]} ^ 128'h5;
  endfunction

  function automatic int ref_grant(input logic [NUM_REQ-1:0] m);
    int idx;
    for (int j = 1; j <= NUM_REQ; j++) begin
      idx = (ref_ptr + j) % NUM_REQ;
      if (m[idx[ID_W-1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic set_slots();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_data[i*DATA_W +: DATA_W] = d[i];
      bus.req_key[i*DATA_W +: DATA_W]  = k[i];
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.req_valid   = '0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    bus.rsp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    ref_ptr = NUM_REQ - 1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " req_ready"},  bus.req_ready,  '0);
    chk({tag, " core_start"}, bus.core_start, '0);
    chk({tag, " core_key"},   bus.core_key,   '0);
    chk({tag, " core_data"},  bus.core_data,  '0);
    chk({tag, " rsp_valid"},  bus.rsp_valid,  '0);
    chk({tag, " rsp_id"},     bus.rsp_id,     '0);
    chk({tag, " rsp_data"},   bus.rsp_data,   '0);
    chk({tag, " rsp_err"},    bus.rsp_err,    '0);
  endtask

  // One request from offer to completed response; lat > TIMEOUT means the core never answers.
  task automatic txn(input logic [NUM_REQ-1:0] m, input int lat, input int hold);
    int g, rsp_c, starts, exp_c;
    logic kz, exp_err, busy_rdy;
    logic [DATA_W-1:0] exp_data;
    g        = ref_grant(m);
    kz       = (k[g] == '0);
    exp_err  = kz || (lat > TIMEOUT);
    exp_data = exp_err ? '0 : core_fn(d[g], k[g]);
    exp_c    = kz ? 1 : ((lat > TIMEOUT) ? 2 + TIMEOUT : 2 + lat);
    set_slots();
    bus.req_valid = m;
    #1;
    chk("grant onehot", bus.req_ready, NUM_REQ'(1) << g);
    @(posedge clk); #1;
    ref_ptr  = g;
    starts   = 0;
    rsp_c    = 0;
    busy_rdy = 1'b0;
    for (int c = 1; c <= TIMEOUT + 10; c++) begin
      bus.req_valid   = NUM_REQ'($urandom);
      bus.core_done   = !kz && (lat <= TIMEOUT) && (c == 1 + lat);
      bus.core_result = bus.core_done ? core_fn(d[g], k[g]) : {4{$urandom}};
      #1;
      if (bus.core_start) starts++;
      if (bus.req_ready != '0) busy_rdy = 1'b1;
      if (c == 1 && !kz) begin
        chk("issue core_key", bus.core_key, k[g]);
        chk("issue core_data", bus.core_data, d[g]);
      end
      if (bus.rsp_valid) begin
        rsp_c = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rsp latency", rsp_c, exp_c);
    chk("core_start count", starts, kz ? 0 : 1);
    chk("req_ready while busy", busy_rdy, 1'b0);
    for (int h = 0; h <= hold; h++) begin
      bus.rsp_ready   = (h == hold);
      bus.req_valid   = (h == hold) ? '0 : NUM_REQ'($urandom);
      bus.core_done   = 1'($urandom);
      bus.core_result = {4{$urandom}};
      #1;
      chk("rsp_valid held", bus.rsp_valid, 1'b1);
      chk("rsp_id", bus.rsp_id, g);
      chk("rsp_data", bus.rsp_data, exp_data);
      chk("rsp_err", bus.rsp_err, exp_err);
      chk("req_ready in resp", bus.req_ready, '0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b0;
    bus.core_done = 1'b0;
    #1;
    chk_quiet("after rsp");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      d[i] = '0;
      k[i] = '0;
    end
    set_slots();
    do_reset();
    chk_quiet("reset");

    d[2] = {32{4'h1}};
    k[2] = {32{8'hA5}};
    txn(4'b0100, 3, 0);

    // Fresh reset so the all-valid rotation starts from requester 0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      d[i] = {4{$urandom}};
      k[i] = {4{$urandom}} | 128'h1;
    end
    for (int n = 0; n < 5; n++) begin
      chk("rotation order", ref_grant(4'hF), n % NUM_REQ);
      txn(4'hF, $urandom_range(1, 5), 0);
    end

    k[1] = '0;
    txn(4'b0010, 3, 0);
    k[1] = {4{$urandom}} | 128'h1;

    txn(4'b1000, TIMEOUT + 5, 0);
    txn(4'b0001, TIMEOUT, 0);
    txn(4'b0100, 2, 10);

    // Reset while waiting on the core; the late done must not produce a response.
    set_slots();
    bus.req_valid = 4'b0100;
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst             = 1'b0;
    ref_ptr         = NUM_REQ - 1;
    bus.core_done   = 1'b1;
    bus.core_result = {4{32'hFFFF_FFFF}};
    @(posedge clk); #1;
    bus.core_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk_quiet("post-reset");
      @(posedge clk); #1;
    end
    txn(4'hF, 2, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        d[i] = {4{$urandom}};
        k[i] = ($urandom_range(0, 5) == 0) ? '0 : {4{$urandom}};
      end
      txn(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)),
          ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(1, 6),
          $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
